// File: rtl/riscv_pkg.sv
// Shared definitions for the store path: funct3 store encodings and the store FSM states.
package riscv_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } st_state_e;

    // Only sb/sh/sw/sd exist; the upper half of the funct3 space is illegal for stores.
    function automatic logic st_f3_legal(input logic [2:0] f3);
        return (f3[2] == 1'b0);
    endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane alignment for a store: builds the 16-lane byte mask and the 128-bit
// shifted data spanning the addressed doubleword and the one after it.
module store_align
    import riscv_pkg::*;
(
    input  logic [2:0]   funct3_i,
    input  logic [2:0]   off_i,
    input  logic [63:0]  data_i,
    output logic [15:0]  mask_o,
    output logic [127:0] data_o
);

    logic [7:0]  size_mask;
    logic [63:0] data_keep;

    always_comb begin
        size_mask = 8'hFF;
        unique case (funct3_i)
            F3_SB:   size_mask = 8'h01;
            F3_SH:   size_mask = 8'h03;
            F3_SW:   size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    // Unused upper bytes are zeroed so disabled lanes carry 0 after the shift.
    always_comb begin
        data_keep = '0;
        for (int i = 0; i < 8; i++) begin
            data_keep[i*8 +: 8] = data_i[i*8 +: 8] & {8{size_mask[i]}};
        end
    end

    assign mask_o = {8'h00, size_mask} << off_i;
    assign data_o = {64'h0, data_keep} << {off_i, 3'b000};

endmodule

// File: rtl/store_unit.sv
// Store unit: turns a MEM-stage store into one or two doubleword write beats,
// splitting stores that cross a doubleword boundary.
module store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [63:0]       st_data,
    input  logic [2:0]        st_funct3,
    output logic              st_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic              mem_gnt,
    output logic              stall
);

    st_state_e         state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        be_q, be_d, hi_be_q, hi_be_d;
    logic [63:0]       wdata_q, wdata_d, hi_wdata_q, hi_wdata_d;
    logic              split_q, split_d;
    logic              err_q, err_d;

    logic [15:0]  aln_mask;
    logic [127:0] aln_data;
    logic         accept;
    logic         legal;

    store_align u_align (
        .funct3_i (st_funct3),
        .off_i    (st_addr[2:0]),
        .data_i   (st_data),
        .mask_o   (aln_mask),
        .data_o   (aln_data)
    );

    assign accept = st_valid && st_ready;
    assign legal  = st_f3_legal(st_funct3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && legal) state_d = BEAT0;
            BEAT0:   if (mem_gnt) state_d = split_q ? BEAT1 : IDLE;
            BEAT1:   if (mem_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        st_ready = (state_q == IDLE);
        stall    = (state_q != IDLE);
    end

    // Beat payload: the second beat is parked in hi_* until the first is granted.
    always_comb begin
        req_d      = req_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        hi_be_d    = hi_be_q;
        hi_wdata_d = hi_wdata_q;
        split_d    = split_q;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && legal) begin
                    req_d      = 1'b1;
                    addr_d     = {st_addr[ADDR_W-1:3], 3'b000};
                    be_d       = aln_mask[7:0];
                    wdata_d    = aln_data[63:0];
                    hi_be_d    = aln_mask[15:8];
                    hi_wdata_d = aln_data[127:64];
                    split_d    = |aln_mask[15:8];
                end else if (accept) begin
                    err_d = 1'b1;
                end
            end
            BEAT0: begin
                if (mem_gnt) begin
                    if (split_q) begin
                        addr_d  = addr_q + ADDR_W'(8);
                        be_d    = hi_be_q;
                        wdata_d = hi_wdata_q;
                    end else begin
                        req_d = 1'b0;
                    end
                end
            end
            BEAT1: begin
                if (mem_gnt) req_d = 1'b0;
            end
            default: req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            hi_be_q    <= '0;
            hi_wdata_q <= '0;
            split_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            req_q      <= req_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            hi_be_q    <= hi_be_d;
            hi_wdata_q <= hi_wdata_d;
            split_q    <= split_d;
            err_q      <= err_d;
        end
    end

    assign mem_req   = req_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign st_err    = err_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: byte-level reference model feeds an expected-beat
// queue; a negedge monitor pops and compares every granted beat and every st_err pulse.
module tb_store_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          st_valid = 1'b0;
    logic          st_ready;
    logic [AW-1:0] st_addr = '0;
    logic [63:0]   st_data = '0;
    logic [2:0]    st_funct3 = '0;
    logic          st_err;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [63:0]   mem_wdata;
    logic [7:0]    mem_be;
    logic          mem_gnt = 1'b0;
    logic          stall;

    store_unit #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_funct3 (st_funct3),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_gnt   (mem_gnt),
        .stall     (stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    be;
        logic [63:0]   wd;
    } beat_t;

    beat_t exp_q[$];
    int    err_pend = 0;
    int    n_cmp = 0;
    int    n_bad = 0;
    bit    gnt_auto = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: place each stored byte at its own absolute address.
    task automatic push_model(input logic [2:0] f3, input logic [AW-1:0] a, input logic [63:0] d);
        beat_t         b0, b1;
        logic [AW-1:0] base, ba;
        int            sz;
        if (f3[2]) begin
            err_pend++;
            return;
        end
        sz   = 1 << f3[1:0];
        base = a & ~AW'(7);
        b0   = '{base, 8'h00, 64'h0};
        b1   = '{base + AW'(8), 8'h00, 64'h0};
        for (int k = 0; k < sz; k++) begin
            ba = a + AW'(k);
            if ((ba & ~AW'(7)) == base) begin
                b0.be[ba[2:0]] = 1'b1;
                b0.wd[ba[2:0]*8 +: 8] = d[k*8 +: 8];
            end else begin
                b1.be[ba[2:0]] = 1'b1;
                b1.wd[ba[2:0]*8 +: 8] = d[k*8 +: 8];
            end
        end
        exp_q.push_back(b0);
        if (b1.be != 8'h00) exp_q.push_back(b1);
    endtask

    always @(posedge clk) begin
        #1;
        if (gnt_auto) mem_gnt = ($urandom_range(0, 2) != 0);
    end

    // Monitor
    beat_t prev;
    bit    prev_hold = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_req", mem_req, 1'b1);
                chk("hold_payload", {mem_addr, mem_be, mem_wdata}, {prev.addr, prev.be, prev.wd});
            end
            chk("stall_busy", {stall, st_ready}, {mem_req, ~mem_req});
            if (mem_req && mem_gnt) begin
                chk("beat_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_addr", mem_addr, e.addr);
                    chk("beat_be", mem_be, e.be);
                    chk("beat_wdata", mem_wdata, e.wd);
                end
            end
            prev_hold = mem_req && !mem_gnt;
            prev = '{mem_addr, mem_be, mem_wdata};
            if (st_err) begin
                chk("err_expected", err_pend > 0, 1'b1);
                if (err_pend > 0) err_pend--;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [2:0] f3, input logic [AW-1:0] a, input logic [63:0] d);
        int w = 0;
        while (!st_ready && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        if (!st_ready) begin
            chk("ready_timeout", 1'b0, 1'b1);
            return;
        end
        st_valid = 1'b1; st_funct3 = f3; st_addr = a; st_data = d;
        push_model(f3, a, d);
        @(posedge clk); #1;
        st_valid = 1'b0;
        chk("req_latency", mem_req, !f3[2]);
        chk("err_latency", st_err, f3[2]);
    endtask

    task automatic wait_idle();
        int w = 0;
        while (!st_ready && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("idle_timeout", st_ready, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [AW-1:0] a;
        logic [2:0] f3;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {mem_req, mem_addr, mem_be, mem_wdata, st_err}, '0);
        chk("reset_ready", {st_ready, stall}, 2'b10);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'b011, 32'h100, 64'h1122334455667788);
        issue(3'b000, 32'h103, 64'hFFFFFFFFFFFFFFAB);
        issue(3'b010, 32'h106, 64'h00000000DEADBEEF);
        issue(3'b011, 32'hFFFF_FFFC, 64'hA1A2A3A4A5A6A7A8);

        // Grant withheld three cycles: payload must sit still for four.
        wait_idle();
        gnt_auto = 1'b0; mem_gnt = 1'b0;
        d = {$urandom, $urandom};
        issue(3'b001, 32'h10, d);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) mem_gnt = 1'b1;
            chk("wait_req", mem_req, 1'b1);
            chk("wait_payload", {mem_addr, mem_be, mem_wdata}, {32'h10, 8'h03, 48'h0, d[15:0]});
            chk("wait_ready_stall", {st_ready, stall}, 2'b01);
            @(posedge clk); #1;
        end
        mem_gnt = 1'b0;
        chk("wait_done", {mem_req, st_ready}, 2'b01);

        // Illegal funct3.
        issue(3'b100, 32'h200, 64'h55);
        chk("err_ready", st_ready, 1'b1);
        @(posedge clk); #1;
        chk("err_one_cycle", {st_err, mem_req, st_ready}, 3'b001);

        // Reset during the second beat of a split store.
        issue(3'b010, 32'h106, 64'h00000000DEADBEEF);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("beat1_active", {mem_req, mem_addr, mem_be}, {1'b1, 32'h108, 8'h03});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {mem_req, mem_addr, mem_be, mem_wdata, st_err}, '0);
        chk("rst_async_ready", {st_ready, stall}, 2'b10);
        chk("rst_abandoned", exp_q.size(), 1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_release_ready", {st_ready, mem_req}, 2'b10);
        @(posedge clk); #1;
        chk("rst_after_ready", {st_ready, mem_req}, 2'b10);
        gnt_auto = 1'b1;

        for (int n = 0; n < 300; n++) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7))) : AW'($urandom);
            d  = {$urandom, $urandom};
            issue(f3, a, d);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        begin
            int w = 0;
            while ((exp_q.size() != 0 || err_pend != 0) && w < 1000) begin
                @(posedge clk); #1;
                w++;
            end
            chk("drain_beats", exp_q.size(), 0);
            chk("drain_errs", err_pend, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
